// File: rtl/rv_isa_pkg.sv
// ============================================================================
// rv_isa_pkg : RV32I format classes, opcodes and encoder state codes
// Rev 1.0
// ============================================================================
`default_nettype none

package rv_isa_pkg;

  localparam logic [3:0] FMT_R      = 4'd0;
  localparam logic [3:0] FMT_I_ALU  = 4'd1;
  localparam logic [3:0] FMT_LOAD   = 4'd2;
  localparam logic [3:0] FMT_STORE  = 4'd3;
  localparam logic [3:0] FMT_BRANCH = 4'd4;
  localparam logic [3:0] FMT_JAL    = 4'd5;
  localparam logic [3:0] FMT_JALR   = 4'd6;
  localparam logic [3:0] FMT_LUI    = 4'd7;
  localparam logic [3:0] FMT_AUIPC  = 4'd8;

  // Opcodes shared with the single-cycle core's control decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

endpackage

`default_nettype wire

// File: rtl/instr_field_pack.sv
// ============================================================================
// instr_field_pack : combinational RV32I field bundle to 32-bit word packer
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_field_pack
  import rv_isa_pkg::*;
(
  input  logic [3:0]  fmt_class,
  input  logic [2:0]  func3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        misaligned
);

  logic [6:0] funct7;
  logic       is_shift;

  assign funct7   = alt ? FUNCT7_ALT : 7'b0000000;
  assign is_shift = (func3 == 3'b001) || (func3 == 3'b101);

  always_comb begin
    word       = 32'd0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (fmt_class)
      FMT_R:      word = {funct7, rs2, rs1, func3, rd, OP_R};
      FMT_I_ALU: begin
        // Shift-immediates carry funct7 above a 5-bit shamt
        if (is_shift)
          word = {funct7, imm[4:0], rs1, func3, rd, OP_I_ALU};
        else
          word = {imm[11:0], rs1, func3, rd, OP_I_ALU};
      end
      FMT_LOAD:   word = {imm[11:0], rs1, func3, rd, OP_LOAD};
      FMT_STORE:  word = {imm[11:5], rs2, rs1, func3, imm[4:0], OP_STORE};
      FMT_BRANCH: begin
        word       = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], OP_BRANCH};
        misaligned = imm[0];
      end
      FMT_JAL: begin
        word       = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        misaligned = imm[0];
      end
      FMT_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      FMT_LUI:    word = {imm[31:12], rd, OP_LUI};
      FMT_AUIPC:  word = {imm[31:12], rd, OP_AUIPC};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder : streaming RV32I encoder writing words into instruction memory
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            fmt_class,
  input  logic [2:0]            func3,
  input  logic                  alt,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  err_illegal,
  output logic                  err_align
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [ADDR_WIDTH:0] accepted;
  logic                drain;
  logic [31:0]         packed_word;
  logic                pack_illegal;
  logic                pack_misaligned;
  logic                transfer;
  logic                legal_xfer;
  logic                arm;
  logic                last_write;

  instr_field_pack u_pack (
    .fmt_class  (fmt_class),
    .func3      (func3),
    .alt        (alt),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .word       (packed_word),
    .illegal    (pack_illegal),
    .misaligned (pack_misaligned)
  );

  assign transfer   = in_valid & in_ready;
  assign legal_xfer = transfer & ~pack_illegal;
  assign arm        = start & ((state == ST_IDLE) | (state == ST_FULL));
  assign last_write = imem_we & (imem_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // A finish that lands on an in-flight write lets that write retire first
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN: begin
        if (drain)                    state_nx = ST_IDLE;
        else if (finish && !imem_we)  state_nx = ST_IDLE;
        else if (last_write)          state_nx = ST_FULL;
      end
      ST_FULL: begin
        if (start)                    state_nx = ST_RUN;
        else if (finish || drain)     state_nx = ST_IDLE;
      end
      default:                        state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_RUN);
    in_ready = (state == ST_RUN) & ~finish & ~drain & (accepted < DEPTH_CNT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain       <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      count       <= '0;
      accepted    <= '0;
      err_illegal <= 1'b0;
      err_align   <= 1'b0;
    end else begin
      drain   <= (state == ST_RUN) & finish & imem_we & ~drain;
      imem_we <= legal_xfer;
      if (legal_xfer) imem_wdata <= packed_word;
      if (arm) begin
        imem_addr   <= '0;
        count       <= '0;
        accepted    <= '0;
        err_illegal <= 1'b0;
        err_align   <= 1'b0;
      end else begin
        // Pointer parks on the last word; the accept limit keeps it from wrapping
        if (imem_we) begin
          if (imem_addr != LAST_ADDR) imem_addr <= imem_addr + ADDR_ONE;
          if (count != DEPTH_CNT)     count     <= count + CNT_ONE;
        end
        if (legal_xfer)                  accepted    <= accepted + CNT_ONE;
        if (transfer && pack_illegal)    err_illegal <= 1'b1;
        if (transfer && pack_misaligned) err_align   <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder, the inverse of the opcode/func3 control decoder.
- Accepts decoded instruction fields over a valid/ready handshake and builds the 32-bit machine word.
- Writes each word sequentially into instruction memory through a write port.
- Used by the bench and boot loader to load programs into the single-cycle core's ROM/RAM without an external assembler.

Parameters:
- ADDR_WIDTH, 6, word-index width of the instruction memory; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  arm the encoder and clear the write pointer (honoured in IDLE and FULL).
- finish  in  1  stop accepting; return to IDLE after the pending write drains.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept this cycle.
- fmt_class  in  4  0 R, 1 I_ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 illegal.
- func3  in  3  funct3 field.
- alt  in  1  selects funct7=0100000 (sub/sra/srai); otherwise 0000000.
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  32  signed immediate, byte units.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_WIDTH  word index.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_WIDTH+1  words written since start.
- busy  out  1  state is RUN.
- err_illegal  out  1  sticky: an illegal fmt_class was accepted.
- err_align  out  1  sticky: BRANCH/JAL accepted with imm[0]=1.

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; pointer, accept counter, count and sticky flags cleared. Outputs are registered.
- States and transitions:
  - IDLE: start → RUN, pointer=0, count=0, errors cleared.
  - RUN: finish with no pending write → IDLE; finish with a pending write → IDLE one cycle later. Writing word DEPTH-1 → FULL.
  - FULL: start → RUN with pointer cleared; finish → IDLE.
- in_ready = (state==RUN) & ~finish & (accepted < DEPTH).
- A transfer occurs when in_valid & in_ready.
- Latency and throughput:
  - Transfer at edge k: encoded word registered at k; imem_we=1 during cycle k+1 with imem_addr=pointer.
  - Pointer and count increment at edge k+1.
  - Back-to-back transfers give one write per cycle.
- Illegal class: transfer still completes and err_illegal is set. No write occurs and no counter advances.
- Encoding (opcode per class: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111):
  - R: {alt?0100000:0, rs2, rs1, func3, rd, op}.
  - I_ALU: func3 001/101 → {alt?0100000:0, imm[4:0], rs1, func3, rd, op}; otherwise imm[11:0] in bits 31:20.
  - LOAD: imm[11:0], rs1, func3, rd.
  - JALR: imm[11:0], rs1, funct3 forced to 000, rd.
  - STORE: {imm[11:5], rs2, rs1, func3, imm[4:0], op}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], op}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - LUI/AUIPC: {imm[31:12], rd, op}.
  - Immediate bits outside a field are silently dropped (truncation, no error).
  - BRANCH/JAL with imm[0]=1: sets err_align; the word is still written with bit 0 discarded.
- Simultaneous events: start and finish together → start wins. start while in RUN is ignored.
- Pointer wrap is impossible: FULL blocks further transfers. count saturates at DEPTH.
- Reset mid-write: the strobe drops immediately; nothing partial persists in the encoder.

Decomposition:
- Shared package rv_isa_pkg holds:
  - fmt_class encodings;
  - the nine RV32I opcode constants (shared with the control decoder);
  - FUNCT7_ALT = 7'b0100000.
- One natural sub-module: instr_field_pack, purely combinational class+fields → 32-bit word. The top holds the FSM, handshake, pointer/counters and output registers.

Test Plan:
- R class, rd=3, rs1=1, rs2=2, func3=0: alt=0 → 0x002081B3 at addr 0; alt=1 → 0x402081B3 at addr 1, written on consecutive cycles.
- I_ALU rd=1, rs1=0, imm=5 → 0x00500093. STORE rs1=1, rs2=2, func3=010, imm=8 → 0x0020A423.
- BRANCH rs1=1, rs2=2, func3=0, imm=-4 → 0xFE208EE3. JAL rd=1, imm=8 → 0x008000EF. LUI rd=5, imm=0x10010000 → 0x100102B7. err_align stays 0.
- ADDR_WIDTH=2 with in_valid held high for 5 bundles:
  - 4 writes to addrs 0-3, then in_ready=0 and state FULL, count=4;
  - start → write pointer back to 0.
- fmt_class=12 → no imem_we, err_illegal=1, count unchanged; a following legal bundle writes at the same address.
- reset pulled low the cycle after a transfer → imem_we=0 immediately, all outputs 0; after release the state is IDLE and in_ready=0 until start.
